// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals shared between the cpu,
// the unified memory and mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_i;
  logic [DATA_WIDTH-1:0] if_addr_i;
  logic                  if_ack_o;
  logic [DATA_WIDTH-1:0] if_rdata_o;

  logic                  dm_req_i;
  logic                  dm_we_i;
  logic                  dm_byte_i;
  logic [DATA_WIDTH-1:0] dm_addr_i;
  logic [DATA_WIDTH-1:0] dm_wdata_i;
  logic                  dm_ack_o;
  logic [DATA_WIDTH-1:0] dm_rdata_o;

  logic                  mem_en_o;
  logic                  mem_we_o;
  logic                  mem_byte_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  stall_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_byte_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_ack_o, if_rdata_o,
    output dm_ack_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    output stall_o
  );

  // Cpu / memory side
  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_byte_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_ack_o, if_rdata_o,
    input  dm_ack_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_byte_o, mem_addr_o, mem_wdata_o,
    input  stall_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction
// fetch and data load/store, with a fixed MEM_LAT-cycle access.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic {SRC_IF, SRC_DM} src_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t                state, state_nxt;
  src_t                  last, last_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] acc_addr, acc_addr_nxt;
  logic [DATA_WIDTH-1:0] acc_wdata, acc_wdata_nxt;
  logic                  acc_we, acc_we_nxt;
  logic                  acc_byte, acc_byte_nxt;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_nxt;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_nxt;
  logic                  grant_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last       <= SRC_DM;
      cnt        <= '0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      acc_we     <= 1'b0;
      acc_byte   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      cnt        <= cnt_nxt;
      acc_addr   <= acc_addr_nxt;
      acc_wdata  <= acc_wdata_nxt;
      acc_we     <= acc_we_nxt;
      acc_byte   <= acc_byte_nxt;
      if_rdata_q <= if_rdata_nxt;
      dm_rdata_q <= dm_rdata_nxt;
    end
  end

  // 'last' doubles as the owner of the access in flight: it is set to the
  // winner at the grant edge and not touched again until the next grant.
  assign grant_dm = bus.dm_req_i & (~bus.if_req_i | (last == SRC_IF));

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    cnt_nxt       = cnt;
    acc_addr_nxt  = acc_addr;
    acc_wdata_nxt = acc_wdata;
    acc_we_nxt    = acc_we;
    acc_byte_nxt  = acc_byte;
    if_rdata_nxt  = if_rdata_q;
    dm_rdata_nxt  = dm_rdata_q;

    case (state)
      IDLE: begin
        if (bus.if_req_i || bus.dm_req_i) begin
          state_nxt = ACCESS;
          cnt_nxt   = CNT_LOAD;
          if (grant_dm) begin
            last_nxt      = SRC_DM;
            acc_addr_nxt  = bus.dm_addr_i;
            acc_wdata_nxt = bus.dm_wdata_i;
            acc_we_nxt    = bus.dm_we_i;
            acc_byte_nxt  = bus.dm_byte_i;
          end else begin
            last_nxt      = SRC_IF;
            acc_addr_nxt  = bus.if_addr_i;
            acc_wdata_nxt = '0;
            acc_we_nxt    = 1'b0;
            acc_byte_nxt  = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = DONE;
          if (!acc_we) begin
            if (last == SRC_DM) dm_rdata_nxt = bus.mem_rdata_i;
            else                if_rdata_nxt = bus.mem_rdata_i;
          end
        end
      end

      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_en_o    = (state == ACCESS);
  assign bus.mem_we_o    = (state == ACCESS) & acc_we;
  assign bus.mem_byte_o  = (state == ACCESS) & acc_byte;
  assign bus.mem_addr_o  = acc_addr;
  assign bus.mem_wdata_o = acc_wdata;

  assign bus.if_ack_o    = (state == DONE) & (last == SRC_IF);
  assign bus.dm_ack_o    = (state == DONE) & (last == SRC_DM);
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;

  assign bus.stall_o = (bus.if_req_i & ~bus.if_ack_o) | (bus.dm_req_i & ~bus.dm_ack_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=2,
// a second at MEM_LAT=1 for back-to-back fetch spacing.
module tb_mem_port_arbiter;
  localparam int DW    = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW)) a ();
  mem_port_arbiter_if #(.DATA_WIDTH(DW)) b ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_LAT(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave)
  );
  mem_port_arbiter #(.DATA_WIDTH(DW), .MEM_LAT(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave)
  );

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
  } exp_t;

  exp_t sb_a[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    if (addr == 32'h10) return 32'h0050_0093;
    return {addr[15:0] ^ 16'hC3A5, ~addr[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory models: read data is only valid in the MEM_LAT-th cycle of mem_en_o.
  int en_cnt_a, en_cnt_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_cnt_a <= 0;
      en_cnt_b <= 0;
    end else begin
      en_cnt_a <= a.mem_en_o ? en_cnt_a + 1 : 0;
      en_cnt_b <= b.mem_en_o ? en_cnt_b + 1 : 0;
    end
  end
  assign a.mem_rdata_i = (a.mem_en_o && en_cnt_a == LAT_A - 1) ? mem_val(a.mem_addr_o) : 32'hDEAD_BEEF;
  assign b.mem_rdata_i = (b.mem_en_o && en_cnt_b == LAT_B - 1) ? mem_val(b.mem_addr_o) : 32'hDEAD_BEEF;

  // Instance A monitor: pops the scoreboard on every ack.
  int   a_acks = 0, a_en_run = 0, a_if_cyc = -1, a_dm_cyc = -1;
  exp_t e_a;
  always @(negedge clk) begin
    if (!rst) begin
      a_en_run = 0;
    end else begin
      if (a.mem_en_o) a_en_run++;
      if (a.if_ack_o || a.dm_ack_o) begin
        chk("a_one_ack", 32'(a.if_ack_o & a.dm_ack_o), 0);
        chk("a_en_len", a_en_run, LAT_A);
        a_en_run = 0;
        chk("a_sb_pending", 32'(sb_a.size() != 0), 1);
        if (sb_a.size() != 0) begin
          e_a = sb_a.pop_front();
          chk("a_ack_src", 32'(a.dm_ack_o), 32'(e_a.is_dm));
          chk("a_rdata", e_a.is_dm ? a.dm_rdata_o : a.if_rdata_o, e_a.data);
        end
        if (a.dm_ack_o) a_dm_cyc = cyc;
        else            a_if_cyc = cyc;
        a_acks++;
      end
    end
  end

  // Instance B monitor: continuous fetch of a fixed address.
  int b_acks = 0, b_en_run = 0, b_prev = -1;
  always @(negedge clk) begin
    if (!rst) begin
      b_en_run = 0;
    end else begin
      if (b.mem_en_o) b_en_run++;
      if (b.if_ack_o) begin
        chk("b_en_len", b_en_run, LAT_B);
        b_en_run = 0;
        chk("b_rdata", b.if_rdata_o, mem_val(32'h40));
        if (b_prev >= 0) chk("b_spacing", cyc - b_prev, 3);
        b_prev = cyc;
        b_acks++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_a(input int target, input logic stall_chk, input logic bus_chk,
                        input logic [31:0] addr, input logic we, input logic byt,
                        input logic [31:0] wdata);
    int n = 0;
    while (a_acks < target && n < 40) begin
      step();
      n++;
      if (stall_chk && a_acks < target) chk("stall_pending", 32'(a.stall_o), 1);
      if (bus_chk && a.mem_en_o) begin
        chk("bus_addr", a.mem_addr_o, addr);
        chk("bus_we", 32'(a.mem_we_o), 32'(we));
        chk("bus_byte", 32'(a.mem_byte_o), 32'(byt));
        chk("bus_wdata", a.mem_wdata_o, wdata);
      end
    end
    chk("a_ack_timeout", a_acks, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] exp_dm;
  int          base;

  initial begin
    a.if_req_i = 0; a.if_addr_i = '0;
    a.dm_req_i = 0; a.dm_we_i = 0; a.dm_byte_i = 0; a.dm_addr_i = '0; a.dm_wdata_i = '0;
    b.if_req_i = 0; b.if_addr_i = '0;
    b.dm_req_i = 0; b.dm_we_i = 0; b.dm_byte_i = 0; b.dm_addr_i = '0; b.dm_wdata_i = '0;
    exp_dm = '0;

    // Reset state
    step(); step();
    chk("rst_mem_en", 32'(a.mem_en_o), 0);
    chk("rst_mem_addr", a.mem_addr_o, 0);
    chk("rst_if_ack", 32'(a.if_ack_o), 0);
    chk("rst_dm_ack", 32'(a.dm_ack_o), 0);
    chk("rst_if_rdata", a.if_rdata_o, 0);
    chk("rst_dm_rdata", a.dm_rdata_o, 0);
    chk("rst_b_mem_en", 32'(b.mem_en_o), 0);
    rst = 1'b1;
    step(); step();

    // Lone fetch
    base = a_acks;
    a.if_req_i = 1; a.if_addr_i = 32'h10;
    sb_a.push_back('{is_dm: 1'b0, data: 32'h0050_0093});
    #1 chk("t2_stall_req", 32'(a.stall_o), 1);
    wait_a(base + 1, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    chk("t2_stall_ack", 32'(a.stall_o), 0);
    a.if_req_i = 0;
    step();
    chk("t2_stall_after", 32'(a.stall_o), 0);
    chk("t2_ack_pulse", 32'(a.if_ack_o), 0);
    chk("t2_en_after", 32'(a.mem_en_o), 0);

    // Reset in the middle of an access
    base = a_acks;
    a.if_req_i = 1; a.if_addr_i = 32'h44;
    step();
    chk("t1_en_before", 32'(a.mem_en_o), 1);
    #2 rst = 1'b0;
    #1;
    chk("t1_mem_en", 32'(a.mem_en_o), 0);
    chk("t1_mem_addr", a.mem_addr_o, 0);
    chk("t1_if_ack", 32'(a.if_ack_o), 0);
    chk("t1_if_rdata", a.if_rdata_o, 0);
    chk("t1_dm_rdata", a.dm_rdata_o, 0);
    a.if_req_i = 0;
    exp_dm = '0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_idle_en", 32'(a.mem_en_o), 0);
    end
    chk("t1_no_ack", a_acks, base);

    // Tie after reset: fetch first; fetch re-requests, so the next tie goes to data
    base = a_acks;
    a.if_req_i = 1; a.if_addr_i = 32'h20;
    a.dm_req_i = 1; a.dm_we_i = 0; a.dm_byte_i = 0; a.dm_addr_i = 32'h200;
    sb_a.push_back('{is_dm: 1'b0, data: mem_val(32'h20)});
    sb_a.push_back('{is_dm: 1'b1, data: mem_val(32'h200)});
    wait_a(base + 1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    a.if_addr_i = 32'h24;
    sb_a.push_back('{is_dm: 1'b0, data: mem_val(32'h24)});
    wait_a(base + 2, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    a.dm_req_i = 0;
    exp_dm = mem_val(32'h200);
    chk("t3_gap_if_dm", a_dm_cyc - a_if_cyc, LAT_A + 2);
    wait_a(base + 3, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    a.if_req_i = 0;
    chk("t3_gap_dm_if", a_if_cyc - a_dm_cyc, LAT_A + 2);

    // Byte store: dm_rdata must keep the previous load value
    step();
    base = a_acks;
    a.dm_req_i = 1; a.dm_we_i = 1; a.dm_byte_i = 1; a.dm_addr_i = 32'h100; a.dm_wdata_i = 32'hAB;
    sb_a.push_back('{is_dm: 1'b1, data: exp_dm});
    wait_a(base + 1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'hAB);
    a.dm_req_i = 0; a.dm_we_i = 0; a.dm_byte_i = 0; a.dm_wdata_i = '0;

    // Load whose address changes and request drops mid-access
    step();
    base = a_acks;
    a.dm_req_i = 1; a.dm_addr_i = 32'h300;
    exp_dm = mem_val(32'h300);
    sb_a.push_back('{is_dm: 1'b1, data: exp_dm});
    step();
    chk("t5_en", 32'(a.mem_en_o), 1);
    a.dm_addr_i = 32'h3FC;
    a.dm_req_i  = 0;
    wait_a(base + 1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_restart", 32'(a.mem_en_o), 0);
    end
    chk("t5_ack_count", a_acks, base + 1);
    chk("t5_sb_empty", sb_a.size(), 0);

    // MEM_LAT=1, continuous fetch
    b.if_req_i = 1; b.if_addr_i = 32'h40;
    for (int n = 0; n < 40 && b_acks < 5; n++) step();
    b.if_req_i = 0;
    chk("t6_ack_count", b_acks, 5);
    for (int i = 0; i < 5; i++) step();
    chk("t6_no_extra_ack", b_acks, 5);
    chk("t6_idle_en", 32'(b.mem_en_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
